// File: rtl/alu_mdu.sv
// RV32I base ALU with a registered 1-cycle result, plus an iterative RV32M
// multiply/divide unit sharing one (XLEN+2)-bit adder, behind valid/ready.
module alu_mdu #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_valid,
    output logic [XLEN-1:0] o_alu_data
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [SHW:0]    cnt;
    logic [2:0]      f3;
    logic            is_div;
    logic            neg;
    logic            div_zero;
    logic [XLEN-1:0] hi;    // product high half / partial remainder
    logic [XLEN-1:0] lo;    // multiplier shifting out / quotient shifting in
    logic [XLEN-1:0] opnd;  // multiplicand / divisor magnitude

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;

    assign o_ready = (state == IDLE);
    assign accept  = i_valid & o_ready;
    assign shamt   = i_op_b[SHW-1:0];

    always_comb begin
        // NOTE: default first so every path assigns base_res and no latch is inferred.
        base_res = '0;
        case (i_op[3:0])
            4'b0000: base_res = i_op_a + i_op_b;
            4'b1000: base_res = i_op_a - i_op_b;
            4'b0001: base_res = i_op_a << shamt;
            4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(i_op_a) < $signed(i_op_b)};
            4'b0011: base_res = {{(XLEN-1){1'b0}}, i_op_a < i_op_b};
            4'b0100: base_res = i_op_a ^ i_op_b;
            4'b0101: base_res = i_op_a >> shamt;
            4'b1101: base_res = $signed(i_op_a) >>> shamt;
            4'b0110: base_res = i_op_a | i_op_b;
            4'b0111: base_res = i_op_a & i_op_b;
            default: base_res = '0;
        endcase
    end

    // Operand preparation at accept: signed operands are reduced to magnitudes
    // and the result sign is remembered for the final fix-up.
    logic [2:0]      f3_in;
    logic            a_signed, b_signed, sa, sb, div_in, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        f3_in    = i_op[2:0];
        a_signed = (f3_in == 3'b001) | (f3_in == 3'b010) | (f3_in == 3'b100) | (f3_in == 3'b110);
        b_signed = (f3_in == 3'b001) | (f3_in == 3'b100) | (f3_in == 3'b110);
        sa       = a_signed & i_op_a[XLEN-1];
        sb       = b_signed & i_op_b[XLEN-1];
        mag_a    = sa ? -i_op_a : i_op_a;
        mag_b    = sb ? -i_op_b : i_op_b;
        div_in   = f3_in[2];
        neg_in   = (f3_in[2] & f3_in[1]) ? sa : (sa ^ sb);
    end

    // One iteration: shift-add for multiply, restoring subtract for divide,
    // both through the same adder (divide adds ~divisor with carry-in 1).
    logic [XLEN:0]   shifted, add_x;
    logic [XLEN+1:0] add_y, sum;
    logic            borrow;
    logic [XLEN-1:0] hi_n, lo_n;

    always_comb begin
        shifted = {hi, lo[XLEN-1]};
        add_x   = is_div ? shifted : {1'b0, hi};
        add_y   = is_div ? ~{2'b00, opnd} : {2'b00, (lo[0] ? opnd : '0)};
        sum     = {1'b0, add_x} + add_y + {{(XLEN+1){1'b0}}, is_div};
        borrow  = sum[XLEN+1];
        if (!is_div) begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end else if (!borrow) begin
            hi_n = sum[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_n = shifted[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b0};
        end
    end

    logic            is_rem;
    logic [XLEN-1:0] div_mag, m_res;

    always_comb begin
        is_rem  = f3[2] & f3[1];
        div_mag = is_rem ? hi_n : lo_n;
        if (is_div) begin
            // A zero-divisor quotient stays all ones regardless of operand signs.
            m_res = (neg && !(div_zero && !is_rem)) ? -div_mag : div_mag;
        end else if (f3 == 3'b000) begin
            m_res = lo_n;
        end else begin
            m_res = neg ? (~hi_n + {{(XLEN-1){1'b0}}, (lo_n == '0)}) : hi_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: the working registers are cleared too, so no stale operand survives an abort.
            state      <= IDLE;
            cnt        <= '0;
            f3         <= '0;
            is_div     <= 1'b0;
            neg        <= 1'b0;
            div_zero   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
            o_valid    <= 1'b0;
            o_alu_data <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !i_op[4]) begin
                        o_alu_data <= base_res;
                        o_valid    <= 1'b1;
                    end else if (accept) begin
                        state    <= BUSY;
                        cnt      <= (SHW+1)'(XLEN);
                        f3       <= f3_in;
                        is_div   <= div_in;
                        neg      <= neg_in;
                        div_zero <= (i_op_b == '0);
                        hi       <= '0;
                        lo       <= div_in ? mag_a : mag_b;
                        opnd     <= div_in ? mag_b : mag_a;
                    end
                end
                BUSY: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == (SHW+1)'(1)) begin
                        o_alu_data <= m_res;
                        o_valid    <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at XLEN=32.
module tb_alu_mdu;

    localparam int XLEN = 32;

    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b01000, OP_SLL = 5'b00001,
                           OP_SLT = 5'b00010, OP_SLTU = 5'b00011, OP_XOR = 5'b00100,
                           OP_SRL = 5'b00101, OP_SRA = 5'b01101, OP_OR = 5'b00110,
                           OP_AND = 5'b00111, OP_BAD = 5'b01111;
    localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010,
                           OP_MULHU = 5'b10011, OP_DIV = 5'b10100, OP_DIVU = 5'b10101,
                           OP_REM = 5'b10110, OP_REMU = 5'b10111;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid;
    logic            ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a, b;
    logic            vld;
    logic [XLEN-1:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(XLEN)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_op       (op),
        .i_op_a     (a),
        .i_op_b     (b),
        .o_valid    (vld),
        .o_alu_data (data)
    );

    // Drive one request, then scramble the operands to show they were captured.
    // Returns the result, the latency in cycles, and how many of those had o_ready=0.
    task automatic issue(input logic [4:0] t_op, input logic [XLEN-1:0] ta, input logic [XLEN-1:0] tb,
                         output logic [XLEN-1:0] res, output int lat, output int busy);
        @(negedge clk);
        op = t_op; a = ta; b = tb; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; a = ~ta; b = ~tb;
        lat = 1; busy = 0;
        while (vld !== 1'b1 && lat < 40) begin
            if (ready === 1'b0) busy++;
            @(negedge clk);
            lat++;
        end
        res = data;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", vld); end
        n_checks++;
        if (data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", data); end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        @(negedge clk);
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: o_valid got %b want 0", vld); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op = OP_SUB; a = 32'd5; b = 32'd10; valid = 1'b1;
        @(negedge clk);
        op = OP_SRA; a = 32'hFFFF_FFF0; b = 32'd2;
        n_checks++;
        if (vld !== 1'b1 || data !== 32'hFFFF_FFFB)
            begin n_fail++; $display("FAIL b2b_sub: got v=%b %h want v=1 fffffffb", vld, data); end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", ready); end
        @(negedge clk);
        valid = 1'b0;
        n_checks++;
        if (vld !== 1'b1 || data !== 32'hFFFF_FFFC)
            begin n_fail++; $display("FAIL b2b_sra: got v=%b %h want v=1 fffffffc", vld, data); end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2: got %b want 1", ready); end
        @(negedge clk);
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL b2b_single_pulse: got %b want 0", vld); end
    endtask

    task automatic test_base();
        logic [4:0]      ops [9] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND, OP_BAD};
        logic [XLEN-1:0] va  [9] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                                     32'h8000_0000, 32'h0F00, 32'hF0F0_F0F0, 32'h5};
        logic [XLEN-1:0] vb  [9] = '{32'h1, 32'h21, 32'h1, 32'h1, 32'hFF00_FF00,
                                     32'h4, 32'h00F0, 32'hFF00_FF00, 32'h3};
        logic [XLEN-1:0] ve  [9] = '{32'h0, 32'h2, 32'h1, 32'h0, 32'h0FF0_0FF0,
                                     32'h0800_0000, 32'h0FF0, 32'hF000_F000, 32'h0};
        logic [XLEN-1:0] res;
        int lat, busy;
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], va[i], vb[i], res, lat, busy);
            n_checks++;
            if (res !== ve[i] || lat != 1)
                begin n_fail++; $display("FAIL base_op%0d(%b): got %h lat %0d want %h lat 1", i, ops[i], res, lat, ve[i]); end
        end
    endtask

    task automatic test_mul();
        logic [XLEN-1:0] res;
        int lat, busy;
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, busy);
        n_checks++;
        if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_data: got %h want ffffffeb", res); end
        n_checks++;
        if (lat != 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
        n_checks++;
        if (busy != 32) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 32", busy); end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready_at_result: got %b want 1", ready); end
        @(negedge clk);
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL mul_single_pulse: got %b want 0", vld); end
    endtask

    task automatic test_mulh();
        logic [4:0]      ops [4] = '{OP_MULH, OP_MULHU, OP_MULHSU, OP_MULHU};
        logic [XLEN-1:0] va  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [XLEN-1:0] ve  [4] = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 32'hFFFF_FFFE};
        logic [XLEN-1:0] res;
        int lat, busy;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], va[i], va[i], res, lat, busy);
            n_checks++;
            if (res !== ve[i] || lat != 33)
                begin n_fail++; $display("FAIL mulh_%0d(%b): got %h lat %0d want %h lat 33", i, ops[i], res, lat, ve[i]); end
        end
    endtask

    task automatic test_div_corners();
        logic [4:0]      ops [10] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REM, OP_DIV, OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [XLEN-1:0] va  [10] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                                      32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [XLEN-1:0] vb  [10] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                      32'd2, 32'd0, 32'd0, 32'd7, 32'd7};
        logic [XLEN-1:0] ve  [10] = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF,
                                      32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd14, 32'd2};
        logic [XLEN-1:0] res;
        int lat, busy;
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], va[i], vb[i], res, lat, busy);
            n_checks++;
            if (res !== ve[i] || lat != 33)
                begin n_fail++; $display("FAIL div_%0d(%b): got %h lat %0d want %h lat 33", i, ops[i], res, lat, ve[i]); end
        end
    endtask

    task automatic test_busy_ignore();
        int k;
        int early;
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = OP_ADD; a = 32'd20; b = 32'd22;
        k = 1; early = 0;
        while (vld !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != 33 || data !== 32'd14)
            begin n_fail++; $display("FAIL busy_div_result: got %h at cycle %0d want 0000000e at 33", data, k); end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL busy_ready_return: got %b want 1", ready); end
        @(negedge clk);
        valid = 1'b0;
        n_checks++;
        if (vld !== 1'b1 || data !== 32'd42)
            begin n_fail++; $display("FAIL busy_add_after: got v=%b %h want v=1 0000002a", vld, data); end
        @(negedge clk);
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL busy_add_single_pulse: got %b want 0", vld); end
    endtask

    task automatic test_reset_mid_op();
        logic [XLEN-1:0] res;
        int lat, busy, pulses;
        @(negedge clk);
        op = OP_MUL; a = 32'd7; b = 32'hFFFF_FFFD; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (vld !== 1'b0 || data !== 32'h0 || ready !== 1'b1)
            begin n_fail++; $display("FAIL midreset_state: got v=%b d=%h r=%b want v=0 d=00000000 r=1", vld, data, ready); end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (vld === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL midreset_stale_pulse: got %0d pulses want 0", pulses); end
        issue(OP_ADD, 32'd1, 32'd2, res, lat, busy);
        n_checks++;
        if (res !== 32'd3 || lat != 1)
            begin n_fail++; $display("FAIL midreset_add: got %h lat %0d want 00000003 lat 1", res, lat); end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; op = '0; a = '0; b = '0;
        test_reset();
        test_back_to_back();
        test_base();
        test_mul();
        test_mulh();
        test_div_corners();
        test_busy_ignore();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
